// File: rtl/prach_hb1_pair.sv
// prach_hb1_pair
//   Pairs even/odd samples of a 16-channel (NUM_CHANNEL) TDM stream for the
//   first PRACH half-band decimator. Even-period samples are parked in a
//   per-channel memory. Each odd-period sample is emitted together with the
//   stored even sample of the same channel, two cycles after it arrives.
//   A small FSM tracks the expected channel, realigns on sync_in and flags
//   sequence errors.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   din_dq/dv/chn      input sample, valid, channel index
//   sync_in            frame marker (even sample of channel 0), qualified by din_dv
//   dout_dp1           odd (later) sample of the pair
//   dout_dp2           even (earlier) sample of the pair
//   dout_dv/chn        pair valid, channel index of the pair
//   sync_out           marks the channel-0 pair whose even sample carried sync_in
//   err_seq            one-cycle pulse on sequence error or unexpected resync
//   dbg_state          current FSM state (0 HUNT, 1 EVEN, 2 ODD)
//
// Handshake: there is no back-pressure. A sample is taken in every cycle
// where din_dv=1. A pair is presented in every cycle where dout_dv=1, and the
// consumer must accept it in that cycle.
module prach_hb1_pair #(
  parameter int NUM_CHANNEL = 16,
  parameter int WIDTH       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_dq,
  input  logic             din_dv,
  input  logic [7:0]       din_chn,
  input  logic             sync_in,
  output logic [WIDTH-1:0] dout_dp1,
  output logic [WIDTH-1:0] dout_dp2,
  output logic             dout_dv,
  output logic [7:0]       dout_chn,
  output logic             sync_out,
  output logic             err_seq,
  output logic [1:0]       dbg_state
);

  localparam int AW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam logic [7:0] LAST_CHN = 8'(NUM_CHANNEL - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [7:0] exp_chn, exp_nx;
  logic       sync_pend, pend_nx;
  logic       err_nx;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          pair_v;
  logic          pair_sync;
  logic          chn_hit;
  logic          chn_last;
  logic [7:0]    exp_inc;

  // Even-sample memory, not reset.
  logic [WIDTH-1:0] mem [NUM_CHANNEL];

  // Stage 1: odd sample plus memory read.
  logic             s1_dv;
  logic             s1_sync;
  logic [7:0]       s1_chn;
  logic [WIDTH-1:0] s1_dp1;
  logic [WIDTH-1:0] s1_dp2;

  assign dbg_state = state;
  assign chn_hit   = (din_chn == exp_chn);
  assign chn_last  = (exp_chn == LAST_CHN);
  assign exp_inc   = chn_last ? 8'd0 : exp_chn + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      exp_chn   <= 8'd0;
      sync_pend <= 1'b0;
      err_seq   <= 1'b0;
    end else begin
      state     <= state_nx;
      exp_chn   <= exp_nx;
      sync_pend <= pend_nx;
      err_seq   <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    exp_nx    = exp_chn;
    pend_nx   = sync_pend;
    err_nx    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = din_chn[AW-1:0];
    pair_v    = 1'b0;
    pair_sync = 1'b0;
    case (state)
      HUNT: begin
        if (din_dv && sync_in && din_chn == 8'd0) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          pend_nx   = 1'b1;
          exp_nx    = 8'd1;
          state_nx  = EVEN;
        end
      end
      default: begin
        if (din_dv) begin
          if (sync_in && !(state == EVEN && exp_chn == 8'd0)) begin
            // Sync in an unexpected place: flag it and restart as if the
            // marker had been found while hunting.
            err_nx    = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = '0;
            pend_nx   = 1'b1;
            exp_nx    = 8'd1;
            state_nx  = EVEN;
          end else if (!chn_hit) begin
            // Covers out-of-range channel numbers too; the sample is dropped.
            err_nx   = 1'b1;
            exp_nx   = 8'd0;
            state_nx = HUNT;
          end else if (state == EVEN) begin
            mem_we = 1'b1;
            exp_nx = exp_inc;
            if (sync_in) pend_nx = 1'b1;
            if (chn_last) state_nx = ODD;
          end else begin
            pair_v = 1'b1;
            if (exp_chn == 8'd0) begin
              pair_sync = sync_pend;
              pend_nx   = 1'b0;
            end
            exp_nx = exp_inc;
            if (chn_last) state_nx = EVEN;
          end
        end
      end
    endcase
  end

  // Writes happen only in EVEN and reads only in ODD, so the same address is
  // never written and read in one cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= din_dq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_dv   <= 1'b0;
      s1_sync <= 1'b0;
      s1_chn  <= 8'd0;
      s1_dp1  <= '0;
      s1_dp2  <= '0;
    end else begin
      s1_dv   <= pair_v;
      s1_sync <= pair_sync;
      if (pair_v) begin
        s1_chn <= din_chn;
        s1_dp1 <= din_dq;
        s1_dp2 <= mem[din_chn[AW-1:0]];
      end
    end
  end

  // Stage 2: data holds its last value while no pair is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_dv  <= 1'b0;
      sync_out <= 1'b0;
      dout_chn <= 8'd0;
      dout_dp1 <= '0;
      dout_dp2 <= '0;
    end else begin
      dout_dv  <= s1_dv;
      sync_out <= s1_dv & s1_sync;
      if (s1_dv) begin
        dout_chn <= s1_chn;
        dout_dp1 <= s1_dp1;
        dout_dp2 <= s1_dp2;
      end
    end
  end

endmodule

// File: tb/tb_prach_hb1_pair.sv
// Directed bench for prach_hb1_pair. Every cycle checks the outputs against
// an expected queue. A pair entry is due two cycles after its odd input, and
// an err_seq entry is due one cycle after the offending input.
module tb_prach_hb1_pair;

  localparam int EW = 73; // {due[31:0], chn[7:0], dp1[15:0], dp2[15:0], sync}

  logic        clk;
  logic        rst;
  logic [15:0] din_dq;
  logic        din_dv;
  logic [7:0]  din_chn;
  logic        sync_in;
  logic [15:0] dout_dp1;
  logic [15:0] dout_dp2;
  logic        dout_dv;
  logic [7:0]  dout_chn;
  logic        sync_out;
  logic        err_seq;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [EW-1:0] exp_q[$];
  int            err_q[$];

  prach_hb1_pair #(.NUM_CHANNEL(16), .WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .din_dq   (din_dq),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dp1 (dout_dp1),
    .dout_dp2 (dout_dp2),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out),
    .err_seq  (err_seq),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  // Scoreboard: runs after every clock edge.
  task automatic check_cycle();
    logic [EW-1:0] e;
    bit have;
    bit have_err;
    have = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      have = (e[72:41] == 32'(cyc));
    end
    if (have) begin
      void'(exp_q.pop_front());
      chk("dout_dv", 32'(dout_dv), 32'd1);
      chk("dout_chn", 32'(dout_chn), 32'(e[40:33]));
      chk("dout_dp1", 32'(dout_dp1), 32'(e[32:17]));
      chk("dout_dp2", 32'(dout_dp2), 32'(e[16:1]));
      chk("sync_out", 32'(sync_out), 32'(e[0]));
    end else begin
      chk("dout_dv_idle", 32'(dout_dv), 32'd0);
      chk("sync_out_idle", 32'(sync_out), 32'd0);
    end
    have_err = (err_q.size() > 0) && (err_q[0] == cyc);
    if (have_err) void'(err_q.pop_front());
    chk("err_seq", 32'(err_seq), 32'(have_err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  // Driver tasks
  task automatic send(input bit dv, input int chn, input int dq, input bit sy);
    din_dv  = dv;
    din_chn = 8'(chn);
    din_dq  = 16'(dq);
    sync_in = sy;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 0, 0, 1'b0);
  endtask

  // Expect a pair from the input about to be driven (two cycles later).
  task automatic exp_pair(input int chn, input int dp1, input int dp2, input bit sy);
    exp_q.push_back({32'(cyc + 2), 8'(chn), 16'(dp1), 16'(dp2), sy});
  endtask

  task automatic exp_err();
    err_q.push_back(cyc + 1);
  endtask

  task automatic do_reset(input bit dv, input int chn);
    exp_q.delete();
    err_q.delete();
    rst     = 1'b1;
    din_dv  = dv;
    din_chn = 8'(chn);
    din_dq  = 16'hBEEF;
    sync_in = 1'b0;
    tick();
    chk("rst_dp1", 32'(dout_dp1), 32'd0);
    chk("rst_dp2", 32'(dout_dp2), 32'd0);
    chk("rst_chn", 32'(dout_chn), 32'd0);
    chk("rst_dv", 32'(dout_dv), 32'd0);
    chk("rst_sync", 32'(sync_out), 32'd0);
    chk("rst_err", 32'(err_seq), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  // One full channel period. Sample for channel c is base+c.
  // Odd periods expect pairs dp1=base+c, dp2=prev+c.
  task automatic run_period(input int base, input bit odd, input int prev,
                            input bit sy_in, input bit sy_out, input int gap_pct);
    for (int c = 0; c < 16; c++) begin
      while ($urandom_range(99, 0) < gap_pct)
        send(1'b0, int'($urandom_range(255, 0)), int'($urandom_range(65535, 0)),
             1'($urandom_range(1, 0)));
      if (odd) exp_pair(c, base + c, prev + c, sy_out && c == 0);
      send(1'b1, c, base + c, sy_in && c == 0);
    end
  endtask

  initial begin
    rst = 1'b1; din_dv = 1'b0; din_chn = 8'd0; din_dq = 16'd0; sync_in = 1'b0;
    do_reset(1'b0, 0);

    // Gapless stream, sync on first ch0.
    run_period(16'h0000, 1'b0, 0, 1'b1, 1'b0, 0);
    chk("state_odd", 32'(dbg_state), 32'd2);
    run_period(16'h0100, 1'b1, 16'h0000, 1'b0, 1'b1, 0);
    chk("state_even", 32'(dbg_state), 32'd1);
    run_period(16'h0200, 1'b0, 0, 1'b0, 1'b0, 0);
    run_period(16'h0300, 1'b1, 16'h0200, 1'b0, 1'b0, 0);
    idle(4);
    chk("hold_dp1", 32'(dout_dp1), 32'h030F);
    chk("hold_dp2", 32'(dout_dp2), 32'h020F);
    chk("hold_chn", 32'(dout_chn), 32'd15);

    // Pre-sync data is ignored, then sync on ch0.
    do_reset(1'b0, 0);
    for (int i = 0; i < 40; i++) send(1'b1, i % 16, 16'h7000 + i, 1'b0);
    chk("presync_state", 32'(dbg_state), 32'd0);
    run_period(16'h1000, 1'b0, 0, 1'b1, 1'b0, 0);
    run_period(16'h1100, 1'b1, 16'h1000, 1'b0, 1'b1, 0);
    idle(3);

    // Same stream with about 30% gaps; gaps carry junk and stray sync_in.
    run_period(16'h0000, 1'b0, 0, 1'b1, 1'b0, 30);
    run_period(16'h0100, 1'b1, 16'h0000, 1'b0, 1'b1, 30);
    run_period(16'h0200, 1'b0, 0, 1'b0, 1'b0, 30);
    run_period(16'h0300, 1'b1, 16'h0200, 1'b0, 1'b0, 30);
    idle(3);

    // Channel skip in ODD: ch5 where ch4 is expected.
    run_period(16'h2000, 1'b0, 0, 1'b1, 1'b0, 0);
    for (int c = 0; c < 4; c++) begin
      exp_pair(c, 16'h2100 + c, 16'h2000 + c, c == 0);
      send(1'b1, c, 16'h2100 + c, 1'b0);
    end
    exp_err();
    send(1'b1, 5, 16'h2105, 1'b0);
    chk("skip_state", 32'(dbg_state), 32'd0);
    for (int c = 6; c < 16; c++) send(1'b1, c, 16'h2100 + c, 1'b0);
    for (int c = 0; c < 16; c++) send(1'b1, c, 16'h2200 + c, 1'b0);
    idle(2);

    // Mid-period resync: sync_in on ch0 while ODD expects ch3.
    run_period(16'h3000, 1'b0, 0, 1'b1, 1'b0, 0);
    for (int c = 0; c < 3; c++) begin
      exp_pair(c, 16'h3100 + c, 16'h3000 + c, c == 0);
      send(1'b1, c, 16'h3100 + c, 1'b0);
    end
    exp_err();
    send(1'b1, 0, 16'h3A00, 1'b1);
    chk("resync_state", 32'(dbg_state), 32'd1);
    for (int c = 1; c < 16; c++) send(1'b1, c, 16'h3A00 + c, 1'b0);
    run_period(16'h3B00, 1'b1, 16'h3A00, 1'b0, 1'b1, 0);
    idle(3);

    // Reset during an ODD burst at ch7.
    run_period(16'h4000, 1'b0, 0, 1'b1, 1'b0, 0);
    for (int c = 0; c < 7; c++) begin
      exp_pair(c, 16'h4100 + c, 16'h4000 + c, c == 0);
      send(1'b1, c, 16'h4100 + c, 1'b0);
    end
    do_reset(1'b1, 7);
    for (int c = 8; c < 16; c++) send(1'b1, c, 16'h4100 + c, 1'b0);
    chk("post_rst_state", 32'(dbg_state), 32'd0);
    run_period(16'h5000, 1'b0, 0, 1'b1, 1'b0, 0);
    run_period(16'h5100, 1'b1, 16'h5000, 1'b0, 1'b1, 0);
    idle(4);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("err_q_drained", 32'(err_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
